// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - instruction prefetch queue between imem port and fetch/decode
//
// Purpose:
//   Issues sequential word-aligned fetch requests to an instruction memory
//   with one or more cycles of response latency, buffers up to Depth
//   returned {addr, instr} pairs, and presents them in order on a
//   valid/ready handshake. A taken jump/branch (flush) empties the queue,
//   marks all in-flight responses as stale and restarts fetching at the
//   target address.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   mem_req      out  fetch request to instruction memory
//   mem_addr     out  fetch address (word aligned)
//   mem_gnt      in   memory accepted the request this cycle
//   mem_rvalid   in   in-order read response valid
//   mem_rdata    in   response instruction word
//   flush        in   taken jump/branch from EXE
//   flush_addr   in   jump target (low two bits ignored)
//   instr_valid  out  head entry valid
//   instr_out    out  head instruction
//   instr_addr   out  address of head instruction
//   instr_ready  in   consumer takes the head entry this cycle

module ifetch_prefetch_queue #(
  parameter int                   AddrWidth = 32,
  parameter int                   DataWidth = 32,
  parameter int                   Depth     = 4,
  parameter logic [AddrWidth-1:0] ResetPC   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic [AddrWidth-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata,
  input  logic                 flush,
  input  logic [AddrWidth-1:0] flush_addr,
  output logic                 instr_valid,
  output logic [DataWidth-1:0] instr_out,
  output logic [AddrWidth-1:0] instr_addr,
  input  logic                 instr_ready
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      ifl_wr_q, ifl_wr_d;
  logic [PtrW-1:0]      ifl_rd_q, ifl_rd_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic [CntW-1:0]      discard_q, discard_d;

  logic [AddrWidth-1:0] q_addr_q   [Depth];
  logic [DataWidth-1:0] q_data_q   [Depth];
  logic [AddrWidth-1:0] ifl_addr_q [Depth];

  logic [CntW:0] credit_used;
  logic          credit_ok;
  logic          grant;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          pop;

  // A request is only issued when every granted word is guaranteed a queue
  // slot on return, so the queue can never overflow. Stale in-flight words
  // still hold credit until they come back and are dropped.
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
  assign credit_ok   = credit_used < (CntW + 1)'(Depth);

  assign mem_req  = !rst && !flush && credit_ok;
  assign mem_addr = fetch_pc_q;
  assign grant    = mem_req && mem_gnt;

  assign rsp_drop = mem_rvalid && (discard_q != '0);
  assign rsp_keep = mem_rvalid && (discard_q == '0) && !flush;

  assign instr_valid = (count_q != '0);
  assign instr_out   = q_data_q[rd_ptr_q];
  assign instr_addr  = q_addr_q[rd_ptr_q];
  assign pop         = instr_valid && instr_ready && !flush;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ifl_wr_d      = ifl_wr_q;
    ifl_rd_d      = ifl_rd_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (flush) begin
      // Everything already requested becomes stale; a response landing in
      // this very cycle is consumed now, so it is not counted again.
      count_d       = '0;
      rd_ptr_d      = wr_ptr_q;
      ifl_rd_d      = ifl_wr_q;
      fetch_pc_d    = flush_addr & ~AddrWidth'(3);
      outstanding_d = outstanding_q - CntW'(mem_rvalid);
      discard_d     = outstanding_q - CntW'(mem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + AddrWidth'(4);
        ifl_wr_d   = ifl_wr_q + PtrW'(1);
      end
      outstanding_d = outstanding_q + CntW'(grant) - CntW'(mem_rvalid);
      // Stale responses never had their address kept, so only kept
      // responses pop the in-flight address FIFO.
      if (rsp_drop) begin
        discard_d = discard_q - CntW'(1);
      end
      if (rsp_keep) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        ifl_rd_d = ifl_rd_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(rsp_keep) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= ResetPC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ifl_wr_q      <= '0;
      ifl_rd_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      for (int i = 0; i < Depth; i++) begin
        q_addr_q[i]   <= '0;
        q_data_q[i]   <= '0;
        ifl_addr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ifl_wr_q      <= ifl_wr_d;
      ifl_rd_q      <= ifl_rd_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (grant) begin
        ifl_addr_q[ifl_wr_q] <= fetch_pc_q;
      end
      if (rsp_keep) begin
        q_addr_q[wr_ptr_q] <= ifl_addr_q[ifl_rd_q];
        q_data_q[wr_ptr_q] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb/tb_ifetch_prefetch_queue.sv - directed and randomized bench for ifetch_prefetch_queue

module tb_ifetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic [31:0] flush_addr;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_addr;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  // memory model state
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          mem_lat = 1;
  bit          rand_lat = 1'b0;
  logic [31:0] pop_addr[$];
  logic [31:0] pop_data[$];
  logic [31:0] gnt_addr[$];

  ifetch_prefetch_queue #(
    .AddrWidth(32),
    .DataWidth(32),
    .Depth(4),
    .ResetPC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .flush(flush),
    .flush_addr(flush_addr),
    .instr_valid(instr_valid),
    .instr_out(instr_out),
    .instr_addr(instr_addr),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic clear_model();
    pend_addr.delete();
    pend_due.delete();
    pop_addr.delete();
    pop_data.delete();
    gnt_addr.delete();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    cyc        = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    flush       = 1'b0;
    flush_addr  = '0;
    mem_gnt     = 1'b0;
    instr_ready = 1'b0;
    rand_lat    = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: entered and left at the falling edge. Grants and
  // responses are sampled before the rising edge; the memory drives the
  // response for the new cycle just after it.
  task automatic tick();
    logic        g;
    logic        rsp;
    logic [31:0] ga;
    #1;
    g   = mem_req && mem_gnt;
    ga  = mem_addr;
    rsp = mem_rvalid;
    if (instr_valid && instr_ready && !flush) begin
      pop_addr.push_back(instr_addr);
      pop_data.push_back(instr_out);
    end
    if (g) gnt_addr.push_back(ga);
    @(posedge clk);
    #1;
    if (rsp && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (g) begin
      pend_addr.push_back(ga);
      pend_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 4)) : mem_lat));
    end
    cyc++;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memfn(pend_addr[0]);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    flush       = 1'b0;
    flush_addr  = '0;
    mem_gnt     = 1'b1;
    instr_ready = 1'b1;
    clear_model();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 00000000", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out got %h exp 00000000", instr_out); end
    checks++; if (instr_addr !== 32'h0) begin errors++; $display("FAIL reset_instr_addr got %h exp 00000000", instr_addr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 00000000", mem_addr); end
  endtask

  task automatic test_streaming();
    do_reset();
    mem_gnt     = 1'b1;
    instr_ready = 1'b1;
    mem_lat     = 1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k < 2) begin
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_startup k=%0d valid got %b exp 0", k, instr_valid); end
      end else begin
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 32'(4 * (k - 2)) || instr_out !== memfn(32'(4 * (k - 2)))) begin
          errors++;
          $display("FAIL stream_out k=%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h",
                   k, instr_valid, instr_addr, instr_out, 32'(4 * (k - 2)), memfn(32'(4 * (k - 2))));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_gnt     = 1'b1;
    instr_ready = 1'b0;
    mem_lat     = 1;
    repeat (10) tick();
    #1;
    checks++; if (gnt_addr.size() != 4) begin errors++; $display("FAIL bp_grants got %0d exp 4", gnt_addr.size()); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got %b exp 0", mem_req); end
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'h0) begin errors++; $display("FAIL bp_head got v=%b a=%h exp v=1 a=00000000", instr_valid, instr_addr); end
    instr_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (pop_addr.size() < 5) begin
      errors++; $display("FAIL bp_drain_count got %0d exp >=5", pop_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pop_addr[i] !== 32'(4 * i) || pop_data[i] !== memfn(32'(4 * i))) begin
          errors++; $display("FAIL bp_drain i=%0d got a=%h d=%h exp a=%h d=%h", i, pop_addr[i], pop_data[i], 32'(4 * i), memfn(32'(4 * i)));
        end
      end
    end
    checks++;
    if (gnt_addr.size() < 5 || gnt_addr[4] !== 32'h10) begin
      errors++; $display("FAIL bp_resume got n=%0d exp grant 00000010", gnt_addr.size());
    end
  endtask

  task automatic test_flush_inflight();
    do_reset();
    mem_gnt     = 1'b1;
    instr_ready = 1'b1;
    mem_lat     = 4;
    repeat (3) tick();
    flush      = 1'b1;
    flush_addr = 32'h0000_0103;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fl_req_in_flush got %b exp 0", mem_req); end
    checks++; if (pend_addr.size() != 3 || mem_rvalid !== 1'b0) begin errors++; $display("FAIL fl_setup got out=%0d rv=%b exp out=3 rv=0", pend_addr.size(), mem_rvalid); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL fl_target_req got r=%b a=%h exp r=1 a=00000100", mem_req, mem_addr); end
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_gap F+%0d valid got %b exp 0", k, instr_valid); end
      tick();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 32'h100 || instr_out !== memfn(32'h100)) begin
      errors++; $display("FAIL fl_first got v=%b a=%h d=%h exp v=1 a=00000100 d=%h", instr_valid, instr_addr, instr_out, memfn(32'h100));
    end
    repeat (10) tick();
    checks++; if (pop_addr.size() < 4) begin errors++; $display("FAIL fl_progress got %0d exp >=4", pop_addr.size()); end
    for (int i = 0; i < pop_addr.size(); i++) begin
      checks++;
      if (pop_addr[i] !== 32'(32'h100 + 4 * i)) begin errors++; $display("FAIL fl_seq i=%0d got %h exp %h", i, pop_addr[i], 32'(32'h100 + 4 * i)); end
    end
  endtask

  task automatic test_flush_coincident();
    do_reset();
    mem_gnt     = 1'b1;
    instr_ready = 1'b1;
    mem_lat     = 2;
    repeat (4) tick();
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 32'h4 || mem_rvalid !== 1'b1 || mem_rdata !== memfn(32'h8)) begin
      errors++; $display("FAIL co_setup got v=%b a=%h rv=%b rd=%h exp v=1 a=00000004 rv=1 rd=%h", instr_valid, instr_addr, mem_rvalid, mem_rdata, memfn(32'h8));
    end
    flush      = 1'b1;
    flush_addr = 32'h0000_0100;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL co_target_req got r=%b a=%h exp r=1 a=00000100", mem_req, mem_addr); end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL co_gap F+%0d valid got %b exp 0", k, instr_valid); end
      tick();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 32'h100) begin
      errors++; $display("FAIL co_first got v=%b a=%h exp v=1 a=00000100", instr_valid, instr_addr);
    end
    repeat (4) tick();
    checks++;
    if (pop_addr.size() < 3 || pop_addr[0] !== 32'h0 || pop_addr[1] !== 32'h100 || pop_addr[2] !== 32'h104) begin
      errors++; $display("FAIL co_pops got n=%0d exp 0,100,104", pop_addr.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_addr;
    int          m_count;
    int          m_disc;
    int          npops;
    logic        exp_req;
    logic        rsp;
    do_reset();
    rand_lat = 1'b1;
    exp_addr = 32'h0;
    m_count  = 0;
    m_disc   = 0;
    npops    = 0;
    for (int c = 0; c < 400; c++) begin
      mem_gnt     = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      flush       = (c % 20 == 19);
      flush_addr  = 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
      #1;
      exp_req = !flush && (m_count + pend_addr.size() < 4);
      checks++; if (mem_req !== exp_req) begin errors++; $display("FAIL rnd_req c=%0d got %b exp %b", c, mem_req, exp_req); end
      checks++; if (instr_valid !== (m_count != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, instr_valid, m_count != 0); end
      checks++; if (m_count + pend_addr.size() > 4) begin errors++; $display("FAIL rnd_credit c=%0d got %0d exp <=4", c, m_count + pend_addr.size()); end
      rsp = mem_rvalid;
      if (!flush && instr_valid && instr_ready) begin
        checks++;
        if (instr_addr !== exp_addr || instr_out !== memfn(exp_addr)) begin
          errors++; $display("FAIL rnd_pop c=%0d got a=%h d=%h exp a=%h d=%h", c, instr_addr, instr_out, exp_addr, memfn(exp_addr));
        end
        exp_addr = exp_addr + 32'h4;
        m_count--;
        npops++;
      end
      if (flush) begin
        m_disc   = pend_addr.size() - (rsp ? 1 : 0);
        m_count  = 0;
        exp_addr = {flush_addr[31:2], 2'b00};
      end else if (rsp) begin
        if (m_disc > 0) m_disc--;
        else m_count++;
      end
      tick();
    end
    flush = 1'b0;
    checks++; if (npops < 100) begin errors++; $display("FAIL rnd_progress got %0d exp >=100", npops); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_gnt     = 1'b1;
    instr_ready = 1'b1;
    mem_lat     = 1;
    repeat (6) tick();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_addr !== 32'h0) begin
      errors++; $display("FAIL arst_outputs got r=%b a=%h v=%b d=%h ia=%h exp all 0", mem_req, mem_addr, instr_valid, instr_out, instr_addr);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL arst_first_req got r=%b a=%h exp r=1 a=00000000", mem_req, mem_addr); end
    repeat (6) tick();
    checks++;
    if (gnt_addr.size() < 1 || gnt_addr[0] !== 32'h0 || pop_addr.size() < 1 || pop_addr[0] !== 32'h0) begin
      errors++; $display("FAIL arst_restart got g=%0d p=%0d exp first grant and pop at 00000000", gnt_addr.size(), pop_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_inflight();
    test_flush_coincident();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
